// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational 32-bit ALU
//
// Purpose: grants one of NUM_REQ requesters per cycle, drives the external ALU
// from the winner and registers the result into that requester's one-entry
// response slot.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   req_valid/req_ready       per-requester request handshake (ready is combinational, one-hot or zero)
//   req_a/req_b/req_func      per-requester operands and function code
//   resp_valid/resp_ready     per-requester response handshake
//   resp_out                  registered result per requester
//   alu_a/alu_b/alu_func      drive to the shared ALU
//   alu_out                   result from the shared ALU
module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0][31:0]    req_a,
  input  logic [NUM_REQ-1:0][31:0]    req_b,
  input  logic [NUM_REQ-1:0][3:0]     req_func,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [NUM_REQ-1:0][31:0]    resp_out,
  output logic [31:0]                 alu_a,
  output logic [31:0]                 alu_b,
  output logic [3:0]                  alu_func,
  input  logic [31:0]                 alu_out
);

  localparam int         LW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_MAX = 4'd9;

  logic [NUM_REQ-1:0]       r_resp_valid;
  logic [NUM_REQ-1:0][31:0] r_resp_out;
  logic [LW-1:0]            r_last_grant;

  logic [NUM_REQ-1:0]       w_elig;
  logic [NUM_REQ-1:0]       w_grant;
  logic                     w_found;
  logic [LW-1:0]            w_idx;
  logic [3:0]               w_func_sel;
  logic                     w_invalid;
  logic [31:0]              w_result;

  // A port may take a new op when its slot is empty or is being drained this cycle.
  assign w_elig = req_valid & (~r_resp_valid | resp_ready);

  // Scan from the port after the last grant, wrapping; first eligible wins.
  always_comb begin
    int      v_idx;
    logic [LW-1:0] v_sel;
    w_found = 1'b0;
    w_idx   = '0;
    v_idx   = 0;
    v_sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = (int'(r_last_grant) + k) % NUM_REQ;
      v_sel = LW'(v_idx);
      if (!w_found && w_elig[v_sel]) begin
        w_found = 1'b1;
        w_idx   = v_sel;
      end
    end
  end

  assign w_grant    = w_found ? (NUM_REQ'(1) << w_idx) : '0;
  assign req_ready  = w_grant;

  assign w_func_sel = req_func[w_idx];
  assign w_invalid  = w_found && (w_func_sel > FUNC_MAX);

  // Unknown codes still run through the ALU as ADD, but their result is discarded.
  assign alu_a    = w_found ? req_a[w_idx] : 32'd0;
  assign alu_b    = w_found ? req_b[w_idx] : 32'd0;
  assign alu_func = (w_found && !w_invalid) ? w_func_sel : FUNC_ADD;
  assign w_result = w_invalid ? 32'd0 : alu_out;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_resp_valid <= '0;
      r_resp_out   <= '0;
      r_last_grant <= LW'(NUM_REQ - 1);
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) begin
          // Accept wins over a same-edge drain so the slot stays full.
          r_resp_out[i]   <= w_result;
          r_resp_valid[i] <= 1'b1;
        end else if (resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
      if (w_found) begin
        r_last_grant <= w_idx;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_out   = r_resp_out;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with two requesters
module tb_alu_arbiter;

  localparam int N = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][31:0]   req_a;
  logic [N-1:0][31:0]   req_b;
  logic [N-1:0][3:0]    req_func;
  logic [N-1:0]         resp_valid;
  logic [N-1:0]         resp_ready;
  logic [N-1:0][31:0]   resp_out;
  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [3:0]           alu_func;
  logic [31:0]          alu_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  always #5 clk_in = ~clk_in;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_func(req_func),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out)
  );

  // Reference ALU the arbiter is shared in front of.
  always_comb begin
    case (alu_func)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a & alu_b;
      4'd3:    alu_out = alu_a | alu_b;
      4'd4:    alu_out = alu_a ^ alu_b;
      4'd5:    alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd6:    alu_out = {31'd0, alu_a < alu_b};
      4'd7:    alu_out = alu_a << alu_b[4:0];
      4'd8:    alu_out = alu_a >> alu_b[4:0];
      4'd9:    alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: whenever a slot presents a result, it must match the oldest
  // expected value for that port; the entry retires when the port consumes it.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (resp_valid[0]) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp0_unexpected: got %h expected none", resp_out[0]);
        end else begin
          chk("resp0", resp_out[0], exp_q0[0]);
          if (resp_ready[0]) void'(exp_q0.pop_front());
        end
      end
      if (resp_valid[1]) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp1_unexpected: got %h expected none", resp_out[1]);
        end else begin
          chk("resp1", resp_out[1], exp_q1[0]);
          if (resp_ready[1]) void'(exp_q1.pop_front());
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    req_valid[p] = 1'b1;
    req_a[p]     = a;
    req_b[p]     = b;
    req_func[p]  = f;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    next_cycle();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in     = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_func   = '0;
    resp_ready = 2'b11;
    #1;
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_resp_out0", resp_out[0], 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_func", {28'd0, alu_func}, 32'd0);
    next_cycle();
    next_cycle();
    rst_in = 1'b0;

    // Single port ADD 5+7.
    set_req(0, 32'd5, 32'd7, 4'd0);
    @(negedge clk_in);
    chk("add_ready", {30'd0, req_ready}, 32'd1);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    exp_q0.push_back(32'd12);
    next_cycle();
    req_valid = '0;
    @(negedge clk_in);
    chk("add_latency", {31'd0, resp_valid[0]}, 32'd1);
    next_cycle();

    // Two contending ports after reset: grants alternate starting at port 0.
    do_reset();
    set_req(0, 32'd10, 32'd3, 4'd1);
    set_req(1, 32'h8000_0000, 32'd4, 4'd9);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      if (c % 2 == 0) begin
        chk("rr_ready_p0", {30'd0, req_ready}, 32'd1);
        chk("rr_func_p0", {28'd0, alu_func}, 32'd1);
        exp_q0.push_back(32'd7);
      end else begin
        chk("rr_ready_p1", {30'd0, req_ready}, 32'd2);
        chk("rr_func_p1", {28'd0, alu_func}, 32'd9);
        exp_q1.push_back(32'hF800_0000);
      end
      next_cycle();
    end
    req_valid = '0;
    next_cycle();

    // Backpressure on port 0 while port 1 keeps flowing.
    resp_ready = 2'b10;
    set_req(0, 32'd1, 32'd1, 4'd0);
    @(negedge clk_in);
    chk("bp_first_ready", {30'd0, req_ready}, 32'd1);
    exp_q0.push_back(32'd2);
    next_cycle();
    set_req(0, 32'hFFFF_FFFF, 32'd1, 4'd5);
    set_req(1, 32'd2, 32'd3, 4'd0);
    @(negedge clk_in);
    chk("bp_blocked", {30'd0, req_ready}, 32'd2);
    exp_q1.push_back(32'd5);
    next_cycle();
    req_valid[1] = 1'b0;
    resp_ready   = 2'b11;
    @(negedge clk_in);
    chk("bp_release", {30'd0, req_ready}, 32'd1);
    exp_q0.push_back(32'd1);
    next_cycle();
    req_valid = '0;
    next_cycle();

    // Streaming on port 0 with no bubble.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 4'd6);
    @(negedge clk_in);
    chk("stream_ready0", {30'd0, req_ready}, 32'd1);
    exp_q0.push_back(32'd0);
    next_cycle();
    set_req(0, 32'd1, 32'd33, 4'd7);
    @(negedge clk_in);
    chk("stream_ready1", {30'd0, req_ready}, 32'd1);
    exp_q0.push_back(32'd2);
    next_cycle();
    req_valid = '0;
    @(negedge clk_in);
    chk("stream_no_bubble", {31'd0, resp_valid[0]}, 32'd1);
    next_cycle();

    // Invalid function code on port 1.
    set_req(1, 32'd3, 32'd4, 4'd12);
    @(negedge clk_in);
    chk("inv_ready", {30'd0, req_ready}, 32'd2);
    chk("inv_alu_func", {28'd0, alu_func}, 32'd0);
    chk("inv_alu_a", alu_a, 32'd3);
    exp_q1.push_back(32'd0);
    next_cycle();
    req_valid = '0;
    next_cycle();

    // Reset between accept and drain discards the pending result.
    resp_ready = 2'b00;
    set_req(0, 32'd5, 32'd7, 4'd0);
    next_cycle();
    req_valid = '0;
    chk("pre_rst_valid", {31'd0, resp_valid[0]}, 32'd1);
    rst_in = 1'b1;
    #1;
    chk("async_rst_valid", {30'd0, resp_valid}, 32'd0);
    chk("async_rst_out0", resp_out[0], 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    next_cycle();
    rst_in     = 1'b0;
    resp_ready = 2'b11;
    set_req(0, 32'd5, 32'd7, 4'd0);
    set_req(1, 32'h0000_F0F0, 32'h0000_FF00, 4'd4);
    @(negedge clk_in);
    chk("post_rst_p0_first", {30'd0, req_ready}, 32'd1);
    exp_q0.push_back(32'd12);
    next_cycle();
    @(negedge clk_in);
    chk("post_rst_p1_next", {30'd0, req_ready}, 32'd2);
    exp_q1.push_back(32'h0000_0FF0);
    next_cycle();
    req_valid = '0;

    // Drain the scoreboard within a bounded number of cycles.
    for (int t = 0; t < 20 && (exp_q0.size() != 0 || exp_q1.size() != 0); t++) next_cycle();
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
